// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream MSB-first into 32-bit words
// and writes them to imem at 0,4,8,...; optional trailing XOR checksum via IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-2:0] num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W-2:0] words_written,
  output logic              chk_err
);

  localparam int CW = ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      xsum;
`else
  assign chk_err = 1'b0;
`endif

  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] n);
    return (n > CW'(DEPTH_WORDS)) ? CW'(DEPTH_WORDS) : n;
  endfunction

  assign cpu_hold = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      byte_ready    <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
      cnt           <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      shift         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_err       <= 1'b0;
      xsum          <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            words_written <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_err       <= 1'b0;
            xsum          <= '0;
`endif
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= RECV;
              byte_ready <= 1'b1;
              cnt        <= sat_count(num_words);
              word_idx   <= '0;
              byte_idx   <= '0;
            end
          end
        end
        RECV: begin
          if (byte_valid && byte_ready) begin
            shift    <= {shift[15:0], byte_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum     <= xsum ^ byte_data;
`endif
            // Fourth byte completes the word; the write strobe appears next cycle.
            if (byte_idx == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              wr_en      <= 1'b1;
              wr_addr    <= {word_idx[ADDR_W-3:0], 2'b00};
              wr_data    <= {shift, byte_data};
            end
          end
        end
        WRITE: begin
          word_idx      <= word_idx + CW'(1);
          words_written <= words_written + CW'(1);
          if (word_idx + CW'(1) == cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= CHECK;
            byte_ready <= 1'b1;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (byte_valid && byte_ready) begin
            chk_err    <= (byte_data != xsum);
            byte_ready <= 1'b0;
            state      <= DONE;
            done       <= 1'b1;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy       <= 1'b0;
          byte_ready <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected imem writes, a monitor pops
// and compares on every wr_en. Define IMEM_LOADER_CHECKSUM_EN to cover the checksum build.
module tb_imem_loader;
  localparam int ADDR_W      = 8;
  localparam int DEPTH_WORDS = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-2:0] num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic [ADDR_W-2:0] words_written;
  logic              chk_err;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .words_written(words_written), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int total = 0;
  int passed = 0;
  int wr_cnt = 0;
  int rdy_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every imem write is matched against the head of the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (byte_ready === 1'b1) rdy_cycles++;
      if (wr_en === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", wr_data, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      total++;
      $display("FAIL byte_accept: got timeout expected byte_ready for 0x%0h", b);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic start_session(input logic [ADDR_W-2:0] n);
    start     = 1'b1;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int gapped, input logic [7:0] flip);
    logic [7:0] xs = 8'h00;
    for (int i = 0; i < stim.size(); i++) begin
      xs ^= stim[i];
      send_byte(stim[i], (gapped != 0) ? (i * 3 + 1) % 4 : 0);
    end
    xs ^= flip;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xs, 0);
`endif
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_cpu_hold_after"}, 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    int wr_base;
    int rdy_base;
    rst = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_wr_en", 32'(wr_en), 32'd0);
    check("idle_wr_addr", 32'(wr_addr), 32'd0);
    check("idle_wr_data", wr_data, 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_words_written", 32'(words_written), 32'd0);
    check("idle_chk_err", 32'(chk_err), 32'd0);
    check("idle_cpu_hold", 32'(cpu_hold), 32'd0);

    // 1: two words, continuous stream
    wr_base = wr_cnt;
    exp_q.push_back('{addr: 8'h00, data: 32'hAC410000});
    exp_q.push_back('{addr: 8'h04, data: 32'h8C850000});
    stim = '{8'hAC, 8'h41, 8'h00, 8'h00, 8'h8C, 8'h85, 8'h00, 8'h00};
    start_session(7'd2);
    check("t1_busy", 32'(busy), 32'd1);
    feed(0, 8'h00);
    wait_done("t1");
    check("t1_words_written", 32'(words_written), 32'd2);
    check("t1_wr_count", 32'(wr_cnt - wr_base), 32'd2);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_chk_err", 32'(chk_err), 32'd0);

    // 2: same program with gaps between bytes
    wr_base = wr_cnt;
    exp_q.push_back('{addr: 8'h00, data: 32'hAC410000});
    exp_q.push_back('{addr: 8'h04, data: 32'h8C850000});
    start_session(7'd2);
    feed(1, 8'h00);
    wait_done("t2");
    check("t2_words_written", 32'(words_written), 32'd2);
    check("t2_wr_count", 32'(wr_cnt - wr_base), 32'd2);

    // 3: zero-length session
    wr_base = wr_cnt;
    rdy_base = rdy_cycles;
    start_session(7'd0);
    check("t3_done_next_cycle", 32'(done), 32'd1);
    @(negedge clk);
    check("t3_done_pulse", 32'(done), 32'd0);
    check("t3_busy_after", 32'(busy), 32'd0);
    check("t3_wr_count", 32'(wr_cnt - wr_base), 32'd0);
    check("t3_ready_cycles", 32'(rdy_cycles - rdy_base), 32'd0);
    check("t3_words_written", 32'(words_written), 32'd0);

    // 4: reset mid-word, then a fresh one-word session from address 0
    wr_base = wr_cnt;
    start_session(7'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_byte_ready", 32'(byte_ready), 32'd0);
    check("t4_rst_cpu_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_no_write_after_rst", 32'(wr_cnt - wr_base), 32'd0);
    exp_q.push_back('{addr: 8'h00, data: 32'h0800003A});
    stim = '{8'h08, 8'h00, 8'h00, 8'h3A};
    start_session(7'd1);
    feed(0, 8'h00);
    wait_done("t4");
    check("t4_words_written", 32'(words_written), 32'd1);
    check("t4_wr_count", 32'(wr_cnt - wr_base), 32'd1);

    // 5: oversize request saturates at DEPTH_WORDS
    wr_base = wr_cnt;
    stim.delete();
    for (int i = 0; i < 4 * DEPTH_WORDS; i++) stim.push_back(8'(i));
    for (int i = 0; i < DEPTH_WORDS; i++)
      exp_q.push_back('{addr: 8'(i * 4),
                        data: {8'(i * 4), 8'(i * 4 + 1), 8'(i * 4 + 2), 8'(i * 4 + 3)}});
    start_session(7'd100);
    feed(0, 8'h00);
    rdy_base = rdy_cycles;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    wait_done("t5");
    byte_valid = 1'b0;
    check("t5_words_written", 32'(words_written), 32'd64);
    check("t5_wr_count", 32'(wr_cnt - wr_base), 32'd64);
    check("t5_last_addr", 32'(wr_addr), 32'h0FC);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t5_extra_byte_refused", 32'(rdy_cycles - rdy_base), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum good (08) then bad (09)
    exp_q.push_back('{addr: 8'h00, data: 32'h12345678});
    stim = '{8'h12, 8'h34, 8'h56, 8'h78};
    start_session(7'd1);
    feed(0, 8'h00);
    wait_done("t6a");
    check("t6_chk_ok", 32'(chk_err), 32'd0);
    exp_q.push_back('{addr: 8'h00, data: 32'h12345678});
    start_session(7'd1);
    check("t6_chk_cleared_on_start", 32'(chk_err), 32'd0);
    feed(0, 8'h01);
    wait_done("t6b");
    check("t6_chk_bad", 32'(chk_err), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_chk_held", 32'(chk_err), 32'd1);
`endif

    repeat (2) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
